// File: rtl/grasshopper_round_ctrl_if.sv
// Block-level bus for the Grasshopper round sequencer: input/output streams,
// key_xor stage port and the S+L request/ack port.
interface grasshopper_round_ctrl_if;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned STAGE_W = 4;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  data_i;
  logic [STAGE_W-1:0] stage_num_o;
  logic [DATA_W-1:0]  kx_data_o;
  logic [DATA_W-1:0]  kx_data_i;
  logic               sl_req_o;
  logic [DATA_W-1:0]  sl_data_o;
  logic               sl_ack_i;
  logic [DATA_W-1:0]  sl_data_i;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  data_o;

  // Controller side
  modport slave (
    input  in_valid, data_i, kx_data_i, sl_ack_i, sl_data_i, out_ready,
    output in_ready, stage_num_o, kx_data_o, sl_req_o, sl_data_o, out_valid, data_o
  );

  // Environment side: source, key_xor, S+L unit and sink
  modport master (
    output in_valid, data_i, kx_data_i, sl_ack_i, sl_data_i, out_ready,
    input  in_ready, stage_num_o, kx_data_o, sl_req_o, sl_data_o, out_valid, data_o
  );
endinterface

// File: rtl/grasshopper_round_ctrl.sv
// Grasshopper round sequencer: 10 key-xor stages interleaved with 9 S+L passes.
// Optional SL watchdog with err_o pulse when GRASS_SL_TIMEOUT_EN is defined.
module grasshopper_round_ctrl (
  input  logic                      clk,
  input  logic                      rst,
  grasshopper_round_ctrl_if.slave   bus,
`ifdef GRASS_SL_TIMEOUT_EN
  output logic                      busy_o,
  output logic                      err_o
`else
  output logic                      busy_o
`endif
);
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned LAST_ROUND = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XOR  = 2'd1,
    ST_SL   = 2'd2,
    ST_DONE = 2'd3
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [DATA_W-1:0]  state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;

`ifdef GRASS_SL_TIMEOUT_EN
  localparam int unsigned WDOG_W     = 8;
  localparam int unsigned WDOG_LIMIT = 255;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state: xor stage, then S+L until the last round, then present result
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
`ifdef GRASS_SL_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.data_i;
          round_d = '0;
          fsm_d   = ST_XOR;
        end
      end
      ST_XOR: begin
        state_d = bus.kx_data_i;
        fsm_d   = (round_q == ROUND_W'(LAST_ROUND)) ? ST_DONE : ST_SL;
`ifdef GRASS_SL_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      ST_SL: begin
        if (bus.sl_ack_i) begin
          state_d = bus.sl_data_i;
          round_d = round_q + ROUND_W'(1);
          fsm_d   = ST_XOR;
`ifdef GRASS_SL_TIMEOUT_EN
        end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
          // 255th unacknowledged SL cycle: abort, state/round left as they are
          fsm_d  = ST_IDLE;
          err_d  = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
`endif
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Data outputs always mirror the registers; only handshakes are state-gated
  assign bus.in_ready    = (fsm_q == ST_IDLE);
  assign bus.sl_req_o    = (fsm_q == ST_SL);
  assign bus.out_valid   = (fsm_q == ST_DONE);
  assign bus.stage_num_o = round_q;
  assign bus.kx_data_o   = state_q;
  assign bus.sl_data_o   = state_q;
  assign bus.data_o      = state_q;
  assign busy_o          = (fsm_q != ST_IDLE);

endmodule

// File: tb/tb_grasshopper_round_ctrl.sv
// Directed bench for grasshopper_round_ctrl with key_xor and S+L stubs.
// Stage constant for stage s is {16{s,~s}}; xor over s=0..9 gives {16{8'h11}}.
module tb_grasshopper_round_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic busy_o;
`ifdef GRASS_SL_TIMEOUT_EN
  logic err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int sl_lat   = 0;
  bit sl_inv   = 1'b0;
  bit sl_never = 1'b0;
  int sl_cnt   = 0;

  grasshopper_round_ctrl_if bus ();

  grasshopper_round_ctrl dut (
    .clk    (clk),
    .rst    (rst_n),
    .bus    (bus),
`ifdef GRASS_SL_TIMEOUT_EN
    .busy_o (busy_o),
    .err_o  (err_o)
`else
    .busy_o (busy_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] key_const(input logic [3:0] s);
    logic [7:0] b;
    b = {s, ~s};
    return {16{b}};
  endfunction

  assign bus.kx_data_i = bus.kx_data_o ^ key_const(bus.stage_num_o);
  assign bus.sl_ack_i  = bus.sl_req_o && !sl_never && (sl_cnt >= sl_lat);
  assign bus.sl_data_i = sl_inv ? ~bus.sl_data_o : bus.sl_data_o;

  always @(posedge clk) begin
    if (!bus.sl_req_o || bus.sl_ack_i) sl_cnt <= 0;
    else                               sl_cnt <= sl_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one block, then return at the first negedge showing out_valid (or on timeout)
  task automatic run_block(input logic [127:0] din, output int lat, output int nxor,
                           output int seq_err, output int stab_err);
    bit prev_wait;
    logic [127:0] prev_sl;
    prev_wait = 1'b0;
    prev_sl   = '0;
    lat = 0; nxor = 0; seq_err = 0; stab_err = 0;
    @(negedge clk);
    bus.data_i   = din;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 400) begin
      if (busy_o && !bus.sl_req_o) begin
        if (bus.stage_num_o != 4'(nxor)) seq_err++;
        nxor++;
      end
      if (prev_wait && (!bus.sl_req_o || bus.sl_data_o !== prev_sl)) stab_err++;
      prev_wait = bus.sl_req_o && !bus.sl_ack_i;
      prev_sl   = bus.sl_data_o;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_block(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val({tag, "_ov_low"}, 128'(bus.out_valid), 128'd0);
    check_val({tag, "_idle"},   128'(bus.in_ready),  128'd1);
    bus.out_ready = 1'b0;
  endtask

  int lat, nxor, seq_err, stab_err;
  logic [127:0] held;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_i    = '0;
    bus.out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check_val("rst_in_ready",  128'(bus.in_ready),    128'd1);
    check_val("rst_out_valid", 128'(bus.out_valid),   128'd0);
    check_val("rst_sl_req",    128'(bus.sl_req_o),    128'd0);
    check_val("rst_busy",      128'(busy_o),          128'd0);
    check_val("rst_stage",     128'(bus.stage_num_o), 128'd0);
    check_val("rst_kx_data",   bus.kx_data_o,         128'd0);
    check_val("rst_data_o",    bus.data_o,            128'd0);
`ifdef GRASS_SL_TIMEOUT_EN
    check_val("rst_err",       128'(err_o),           128'd0);
`endif
    rst_n = 1'b1;

    // Identity S+L, zero-wait ack
    run_block(128'h1122334455667700FFEEDDCCBBAA9988, lat, nxor, seq_err, stab_err);
    check_val("id_latency", 128'(lat),     128'd19);
    check_val("id_nxor",    128'(nxor),    128'd10);
    check_val("id_stages",  128'(seq_err), 128'd0);
    check_val("id_data",    bus.data_o,    128'h0033225544776611EEFFCCDDAABB8899);

    // Output stall with spurious in_valid pulses
    held = bus.data_o;
    for (int i = 0; i < 10; i++) begin
      check_val("stall_ov",   128'(bus.out_valid), 128'd1);
      check_val("stall_data", bus.data_o,          held);
      check_val("stall_rdy",  128'(bus.in_ready),  128'd0);
      bus.in_valid = i[0];
      bus.data_i   = {4{$urandom}};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    finish_block("stall");

    // Three wait cycles per ack, inverting S+L: result is ~(0 ^ K)
    sl_lat = 3; sl_inv = 1'b1;
    run_block(128'd0, lat, nxor, seq_err, stab_err);
    check_val("lat3_latency", 128'(lat),      128'd46);
    check_val("lat3_stages",  128'(seq_err),  128'd0);
    check_val("lat3_stable",  128'(stab_err), 128'd0);
    check_val("lat3_data",    bus.data_o,     {16{8'hEE}});
    finish_block("lat3");

    // Reset in round 4 while requesting S+L
    sl_inv = 1'b0;
    @(negedge clk);
    bus.data_i   = 128'hDEADBEEF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!(bus.sl_req_o && bus.stage_num_o == 4'd4) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val("mid_reach_r4", 128'(bus.sl_req_o && bus.stage_num_o == 4'd4), 128'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_sl_req",   128'(bus.sl_req_o),    128'd0);
    check_val("mid_busy",     128'(busy_o),          128'd0);
    check_val("mid_in_ready", 128'(bus.in_ready),    128'd1);
    check_val("mid_stage",    128'(bus.stage_num_o), 128'd0);
    check_val("mid_data",     bus.data_o,            128'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    sl_lat = 0;
    run_block(128'h000102030405060708090A0B0C0D0E0F, lat, nxor, seq_err, stab_err);
    check_val("post_rst_latency", 128'(lat),  128'd19);
    check_val("post_rst_data",    bus.data_o, 128'h111013121514171619181B1A1D1C1F1E);
    finish_block("post_rst");

    // Back-to-back with in_valid held high
    @(negedge clk);
    bus.data_i    = 128'h1122334455667700FFEEDDCCBBAA9988;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.data_i = {4{32'hFFFFFFFF}};
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val("b2b_a_latency", 128'(lat),  128'd19);
    check_val("b2b_a_data",    bus.data_o, 128'h0033225544776611EEFFCCDDAABB8899);
    @(negedge clk);
    check_val("b2b_idle_gap",  128'(bus.in_ready), 128'd1);
    @(negedge clk);
    check_val("b2b_accept",    128'(busy_o),          128'd1);
    check_val("b2b_stage0",    128'(bus.stage_num_o), 128'd0);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val("b2b_b_latency", 128'(lat),  128'd19);
    check_val("b2b_b_data",    bus.data_o, {16{8'hEE}});
    @(negedge clk);
    check_val("b2b_b_done",    128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b0;

`ifdef GRASS_SL_TIMEOUT_EN
    // Watchdog: never acknowledge
    begin
      int sl_cycles;
      bit ov_seen;
      sl_cycles = 0;
      ov_seen   = 1'b0;
      sl_never  = 1'b1;
      @(negedge clk);
      bus.data_i   = 128'h5;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!err_o && lat < 600) begin
        if (bus.sl_req_o)  sl_cycles++;
        if (bus.out_valid) ov_seen = 1'b1;
        @(negedge clk);
        lat++;
      end
      check_val("wd_err_seen",  128'(err_o),        128'd1);
      check_val("wd_sl_cycles", 128'(sl_cycles),    128'd255);
      check_val("wd_idle",      128'(busy_o),       128'd0);
      check_val("wd_no_ov",     128'(ov_seen),      128'd0);
      @(negedge clk);
      check_val("wd_err_pulse", 128'(err_o),        128'd0);
      check_val("wd_stay_idle", 128'(bus.in_ready), 128'd1);
      sl_never = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grasshopper_round_ctrl.md
# grasshopper_round_ctrl

Round sequencer for the Grasshopper (Kuznyechik) block encoder. It accepts one 128-bit block over a valid/ready handshake and steps the key-xor stage through stage numbers 0..9. After each of the first nine xor stages it hands the state to an external S+L transform unit over a req/ack handshake. The result is presented on a valid/ready output. It sits between the input register stage and the output buffer, and owns the single shared `key_xor` instance and the single shared S+L unit.

## Interface
- No parameters. Round count is fixed: 10 xor stages, 9 S+L passes.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  controller can accept a block.
- `data_i`  in  128  plaintext block.
- `stage_num_o`  out  4  stage number to `key_xor`.
- `kx_data_o`  out  128  state to `key_xor`.
- `kx_data_i`  in  128  `key_xor` result, combinational from `stage_num_o` and `kx_data_o`.
- `sl_req_o`  out  1  S+L request.
- `sl_data_o`  out  128  state to the S+L unit.
- `sl_ack_i`  in  1  S+L result valid; may arrive in the same cycle as the request.
- `sl_data_i`  in  128  S+L result.
- `out_valid`  out  1  encoded block valid.
- `out_ready`  in  1  downstream accepts the block.
- `data_o`  out  128  encoded block.
- `busy_o`  out  1  high in every state except IDLE.
- `err_o`  out  1  present only with `GRASS_SL_TIMEOUT_EN` (see Configuration).

## Operation
- Registers:
  - `state` (128 bits).
  - `round` (4 bits, 0..9).
  - `fsm`, with states IDLE, XOR, SL, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: `state` <= `data_i`, `round` <= 0, go to XOR.
- XOR:
  - `stage_num_o` = `round`, `kx_data_o` = `state`.
  - Next edge: `state` <= `kx_data_i`.
  - If `round` == 9, go to DONE; otherwise go to SL.
- SL:
  - `sl_req_o` = 1, `sl_data_o` = `state`.
  - Held stable until `sl_ack_i` is sampled high.
  - On ack: `state` <= `sl_data_i`, `round` <= `round` + 1, go to XOR.
- DONE:
  - `out_valid` = 1, `data_o` = `state`.
  - On `out_ready`: go to IDLE.
  - `data_o` is stable while stalled.
- Signals outside their active state:
  - `stage_num_o` always reflects `round`.
  - `kx_data_o`, `sl_data_o` and `data_o` always reflect `state`.
  - Only `sl_req_o`, `in_ready` and `out_valid` are gated by state.
- `sl_ack_i` outside SL is ignored.
- `in_valid` outside IDLE is ignored; no block is accepted.
- `round` never exceeds 9 and never wraps.

## Timing
- Reset values: `fsm` = IDLE, `state` = 0, `round` = 0.
- Outputs during reset:
  - `in_ready` = 1.
  - `out_valid`, `sl_req_o`, `busy_o` and `err_o` = 0.
  - `stage_num_o` = 0.
  - All data outputs = 0.
- Latency with zero-wait ack: each round costs XOR 1 cycle + SL 1 cycle, so 9 × 2 + 1 = 19 cycles.
  - Accept edge is edge 0.
  - `out_valid` is high after edge 19.
- Each wait cycle on `sl_ack_i` adds one cycle.
- `sl_req_o` falls the cycle after the ack edge, because the block enters XOR.
- Back-to-back operation: IDLE is a full cycle after the DONE handshake. The next accept is one cycle after `out_valid & out_ready`, giving a minimum of 21 cycles per block.
- Reset asserted mid-operation:
  - All registers clear immediately (asynchronous).
  - `sl_req_o` drops without waiting for ack.
  - The in-flight block is discarded.

## Configuration
- Macro: `GRASS_SL_TIMEOUT_EN`.
- When defined:
  - An 8-bit watchdog counts cycles in SL and clears on entry to SL.
  - If it reaches 255 without an ack, the block is aborted: `fsm` goes to IDLE and `err_o` pulses high for exactly 1 cycle.
  - `state` and `round` keep their values until the next accept.
- When undefined:
  - There is no watchdog, and SL waits indefinitely.
  - The `err_o` port does not exist.

## Test plan
- Identity S+L stub (ack in the same cycle as req, `sl_data_i` = `sl_data_o`):
  - Input: `data_i` = 128'h1122334455667700FFEEDDCCBBAA9988.
  - Expected `data_o`: `data_i` XOR the combined xor of stage constants 0..9, computed by the bench from the `key_xor` model.
  - Expected timing: `out_valid` at cycle 19 after accept.
  - Expected `stage_num_o` sequence across XOR cycles: 0,1,…,9.
- S+L stub with 3-cycle ack latency:
  - Latency becomes 19 + 9 × 3 = 46 cycles.
  - `sl_req_o` and `sl_data_o` stay stable during each wait.
- Output stall: hold `out_ready` = 0 for 10 cycles.
  - `out_valid` and `data_o` stay stable.
  - `in_ready` = 0 throughout.
  - `in_valid` pulses during the stall are ignored.
- Reset mid-operation: assert `rst` = 0 at round 4 while `sl_req_o` = 1.
  - Outputs go to their reset values in the same cycle.
  - After release, a new block completes correctly.
- Back-to-back: two blocks with `in_valid` held high and `out_ready` = 1.
  - Second accept occurs exactly 1 cycle after the first output handshake.
  - Both results are correct.
- With `GRASS_SL_TIMEOUT_EN`: never ack.
  - `err_o` pulses at the 255th SL cycle.
  - `fsm` returns to IDLE.
  - `out_valid` never rises.
